// File: rtl/fft_pkg.sv
// Shared FFT address-generation definitions: FSM state encoding, size helpers
// and the bit-reverse map used by both the AGU and the natural-order loader.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } agu_state_t;

  localparam int LOG2N_DEF = 10;
  localparam int DRAIN_W   = 4;

  // Butterflies per stage for an N = 2^log2n point transform.
  function automatic int fft_b(input int log2n);
    return 1 << (log2n - 1);
  endfunction

  function automatic int fft_stage_w(input int log2n);
    return (log2n > 1) ? $clog2(log2n) : 1;
  endfunction

  // Reverses the low w bits of v (w = 2..16); upper result bits are zero.
  function automatic logic [15:0] bit_rev(input logic [15:0] v, input int w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15 - i];
    return r >> (16 - w);
  endfunction

  localparam int B_DEF       = fft_b(LOG2N_DEF);
  localparam int STAGE_W_DEF = fft_stage_w(LOG2N_DEF);

endpackage

// File: rtl/fft_agu_addr_calc.sv
// Combinational butterfly address map: (stage s, butterfly j) -> lower/upper
// RAM address and twiddle index for an in-place radix-2 FFT.
module fft_agu_addr_calc
  import fft_pkg::*;
#(
  parameter int LOG2N   = 10,
  parameter int STAGE_W = fft_stage_w(LOG2N)
) (
  input  logic [STAGE_W-1:0] s,
  input  logic [LOG2N-2:0]   j,
  output logic [LOG2N-1:0]   mem_addr_0,
  output logic [LOG2N-1:0]   mem_addr_1,
  output logic [LOG2N-2:0]   k
);

  logic [LOG2N-1:0] j_w;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;
  int               sh;

  always_comb begin
    sh         = int'(s);
    j_w        = {1'b0, j};
    span       = (LOG2N)'(1) << sh;
    pos        = j_w & (span - (LOG2N)'(1));
    grp        = j_w >> sh;
    mem_addr_0 = (grp << (sh + 1)) | pos;
    mem_addr_1 = mem_addr_0 | span;
    // pos < 2^s, so the shifted twiddle index always fits in LOG2N-1 bits.
    k          = (LOG2N-1)'(pos << (LOG2N - 1 - sh));
  end

endmodule

// File: rtl/fft_agu_param.sv
// Parametrised radix-2 FFT address generation unit with stall, inter-stage drain
// and optional natural-order bit-reverse load phase (macro AGU_BITREV_EN).
//
// state | meaning
// IDLE  | waiting for fft_start, j = s = 0
// LOAD  | bit-reversed load addresses, N cycles (AGU_BITREV_EN only)
// RUN   | one butterfly per unstalled cycle, j counts 0..B-1
// DRAIN | PIPE_DELAY idle cycles after each stage for writeback
// DONE  | single-cycle fft_done pulse
module fft_agu_param
  import fft_pkg::*;
#(
  parameter int LOG2N      = 10,
  parameter int PIPE_DELAY = 1,
  parameter int STAGE_W    = fft_stage_w(LOG2N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fft_start,
  input  logic               stall,
  output logic [LOG2N-1:0]   mem_addr_0,
  output logic [LOG2N-1:0]   mem_addr_1,
  output logic [LOG2N-2:0]   k,
  output logic [STAGE_W-1:0] n,
  output logic               ram_select,
  output logic               addr_valid,
  output logic               load_valid,
  output logic               stage_done,
  output logic               fft_busy,
  output logic               fft_done
);

  localparam logic [LOG2N-2:0]   J_LAST = (LOG2N-1)'(fft_b(LOG2N) - 1);
  localparam logic [STAGE_W-1:0] S_LAST = (STAGE_W)'(LOG2N - 1);
  localparam logic [DRAIN_W-1:0] D_LOAD =
    (PIPE_DELAY > 0) ? (DRAIN_W)'(PIPE_DELAY - 1) : '0;

  agu_state_t         state, state_nx;
  logic [LOG2N-2:0]   j, j_nx;
  logic [STAGE_W-1:0] s, s_nx;
  logic [DRAIN_W-1:0] dcnt, dcnt_nx;
`ifdef AGU_BITREV_EN
  localparam logic [LOG2N-1:0] LD_LAST = (LOG2N)'((1 << LOG2N) - 1);
  logic [LOG2N-1:0]   ld_cnt, ld_cnt_nx;
`endif

  logic [LOG2N-1:0] calc_a0, calc_a1;
  logic [LOG2N-2:0] calc_k;
  logic [LOG2N-1:0] addr0_c, addr1_c;
  logic [LOG2N-2:0] k_c;
  logic             rsel_c, addr_valid_c, load_valid_c, stage_done_c, done_c;

  fft_agu_addr_calc #(
    .LOG2N  (LOG2N),
    .STAGE_W(STAGE_W)
  ) u_addr_calc (
    .s         (s),
    .j         (j),
    .mem_addr_0(calc_a0),
    .mem_addr_1(calc_a1),
    .k         (calc_k)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      j      <= '0;
      s      <= '0;
      dcnt   <= '0;
`ifdef AGU_BITREV_EN
      ld_cnt <= '0;
`endif
    end else begin
      state  <= state_nx;
      j      <= j_nx;
      s      <= s_nx;
      dcnt   <= dcnt_nx;
`ifdef AGU_BITREV_EN
      ld_cnt <= ld_cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx     = state;
    j_nx         = j;
    s_nx         = s;
    dcnt_nx      = dcnt;
`ifdef AGU_BITREV_EN
    ld_cnt_nx    = ld_cnt;
`endif
    addr0_c      = '0;
    addr1_c      = '0;
    k_c          = '0;
    rsel_c       = ~s[0];
    addr_valid_c = 1'b0;
    load_valid_c = 1'b0;
    stage_done_c = 1'b0;
    done_c       = 1'b0;

    unique case (state)
      IDLE: begin
        j_nx = '0;
        s_nx = '0;
        if (fft_start) begin
`ifdef AGU_BITREV_EN
          state_nx  = LOAD;
          ld_cnt_nx = '0;
`else
          state_nx  = RUN;
`endif
        end
      end
`ifdef AGU_BITREV_EN
      LOAD: begin
        rsel_c       = 1'b0;
        addr0_c      = (LOG2N)'(bit_rev(16'(ld_cnt), LOG2N));
        load_valid_c = ~stall;
        if (!stall) begin
          ld_cnt_nx = ld_cnt + 1'b1;
          if (ld_cnt == LD_LAST) state_nx = RUN;
        end
      end
`endif
      RUN: begin
        addr0_c      = calc_a0;
        addr1_c      = calc_a1;
        k_c          = calc_k;
        addr_valid_c = ~stall;
        if (!stall) begin
          if (j == J_LAST) begin
            j_nx         = '0;
            stage_done_c = 1'b1;
            if (PIPE_DELAY > 0) begin
              state_nx = DRAIN;
              dcnt_nx  = D_LOAD;
            end else if (s == S_LAST) begin
              state_nx = DONE;
            end else begin
              s_nx = s + 1'b1;
            end
          end else begin
            j_nx = j + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (dcnt == '0) begin
            if (s == S_LAST) begin
              state_nx = DONE;
            end else begin
              s_nx     = s + 1'b1;
              state_nx = RUN;
            end
          end else begin
            dcnt_nx = dcnt - 1'b1;
          end
        end
      end
      DONE: begin
        done_c   = 1'b1;
        state_nx = IDLE;
        j_nx     = '0;
        s_nx     = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are forced to their idle values while rst is asserted, not only after the edge.
  assign mem_addr_0 = rst ? addr0_c : '0;
  assign mem_addr_1 = rst ? addr1_c : '0;
  assign k          = rst ? k_c : '0;
  assign n          = rst ? s : '0;
  assign ram_select = rst ? rsel_c : 1'b1;
  assign addr_valid = rst & addr_valid_c;
  assign load_valid = rst & load_valid_c;
  assign stage_done = rst & stage_done_c;
  assign fft_busy   = rst & (state != IDLE);
  assign fft_done   = rst & done_c;

endmodule

// File: tb/tb_fft_agu_param.sv
// Self-checking bench for fft_agu_param (LOG2N=3) with PIPE_DELAY 0 and 2 instances.
module tb_fft_agu_param;

  localparam int L    = 3;
  localparam int NPTS = 8;
  localparam int BF   = 4;
`ifdef AGU_BITREV_EN
  localparam int LOADN = NPTS;
`else
  localparam int LOADN = 0;
`endif

  typedef struct packed {
    logic [2:0] a0;
    logic [2:0] a1;
    logic [1:0] k;
    logic [1:0] n;
    logic rsel, av, lv, sd, busy, done;
  } obs_t;

  typedef struct { int s; int j; int a0; int a1; int k; } vec_t;
  typedef struct { int a0; int a1; int k; int n; bit last; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start [2];
  logic stall [2];
  obs_t obs [2];

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  int   ld_q[$];
  vec_t tbl [12];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [2:0] a0, a1;
    logic [1:0] k, n;
    logic rsel, av, lv, sd, busy, done;
    fft_agu_param #(.LOG2N(L), .PIPE_DELAY(2 * g)) u_dut (
      .clk(clk), .rst(rst), .fft_start(start[g]), .stall(stall[g]),
      .mem_addr_0(a0), .mem_addr_1(a1), .k(k), .n(n), .ram_select(rsel),
      .addr_valid(av), .load_valid(lv), .stage_done(sd), .fft_busy(busy),
      .fft_done(done)
    );
    assign obs[g] = {a0, a1, k, n, rsel, av, lv, sd, busy, done};
  end

  function automatic int pd_of(input int d);
    return 2 * d;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic chk_idle(input int d);
    obs_t o;
    o = obs[d];
    chk("idle_busy", int'(o.busy), 0);
    chk("idle_av", int'(o.av), 0);
    chk("idle_lv", int'(o.lv), 0);
    chk("idle_sd", int'(o.sd), 0);
    chk("idle_done", int'(o.done), 0);
    chk("idle_rsel", int'(o.rsel), 1);
    chk("idle_n", int'(o.n), 0);
  endtask

  task automatic chk_reset(input int d);
    obs_t o;
    o = obs[d];
    chk_idle(d);
    chk("rst_a0", int'(o.a0), 0);
    chk("rst_a1", int'(o.a1), 0);
    chk("rst_k", int'(o.k), 0);
  endtask

  // Expected butterflies: src 1 = literal table, else derived from group/position arithmetic.
  function automatic void build_model(input int src);
    exp_t e;
    exp_q.delete();
    ld_q.delete();
    if (src == 1) begin
      foreach (tbl[i]) begin
        e.a0 = tbl[i].a0; e.a1 = tbl[i].a1; e.k = tbl[i].k; e.n = tbl[i].s;
        e.last = (tbl[i].j == BF - 1);
        exp_q.push_back(e);
      end
    end else begin
      for (int s = 0; s < L; s++) begin
        int span, groups;
        span   = 2 ** s;
        groups = NPTS / (2 * span);
        for (int g = 0; g < groups; g++)
          for (int p = 0; p < span; p++) begin
            e.a0 = g * 2 * span + p; e.a1 = e.a0 + span; e.k = p * groups; e.n = s;
            e.last = (g == groups - 1) && (p == span - 1);
            exp_q.push_back(e);
          end
      end
    end
`ifdef AGU_BITREV_EN
    for (int c = 0; c < NPTS; c++) begin
      int r;
      r = 0;
      for (int b = 0; b < L; b++) if (((c >> b) & 1) == 1) r += 1 << (L - 1 - b);
      ld_q.push_back(r);
    end
`endif
  endfunction

  // mode: 0 no stall, 1 random stall, 2 three stalls on the sixth butterfly (s1, j1)
  task automatic run_fft(input int d, input int mode, input bit hold, input int src);
    obs_t o; exp_t e; bit st;
    bit got_done, seen_sd;
    int cyc, nstall, gap, gap_st, tgt, popped, la;
    got_done = 0; seen_sd = 0; cyc = 0; nstall = 0; gap = 0; gap_st = 0; tgt = 0; popped = 0;
    build_model(src);
    @(posedge clk); #1;
    start[d] = 1'b1;
    @(posedge clk); #1;
    if (!hold) start[d] = 1'b0;
    while (!got_done && cyc < 400) begin
      cyc++;
      case (mode)
        1: st = ($urandom_range(0, 3) == 0);
        2: st = (popped == 5 && tgt < 3);
        default: st = 1'b0;
      endcase
      if (st && mode == 2) tgt++;
      stall[d] = st;
      @(negedge clk);
      o = obs[d];
      if (o.done) begin
        got_done = 1;
        chk("done_cycle", cyc, LOADN + L * (BF + pd_of(d)) + nstall + 1);
        chk("done_busy", int'(o.busy), 1);
        chk("done_av", int'(o.av), 0);
        chk("bfly_left", exp_q.size(), 0);
        chk("load_left", ld_q.size(), 0);
      end else begin
        if (st) nstall++;
        chk("busy", int'(o.busy), 1);
        if (cyc == 1) chk("first_valid", int'(o.av | o.lv), int'(!st));
        if (st) chk("stall_gate", int'(o.av | o.lv), 0);
`ifdef AGU_BITREV_EN
        if (o.lv) begin
          checks++;
          if (ld_q.size() == 0) begin
            errors++;
            $display("FAIL load_extra: got load_valid expected none left at %0t", $time);
          end else begin
            la = ld_q.pop_front();
            chk("load_addr", int'(o.a0), la);
            chk("load_rsel", int'(o.rsel), 0);
            chk("load_av", int'(o.av), 0);
          end
        end
`else
        chk("lv_tied", int'(o.lv), 0);
`endif
        if (o.av) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bfly_extra: got addr_valid expected none left at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            popped++;
            chk("a0", int'(o.a0), e.a0);
            chk("a1", int'(o.a1), e.a1);
            chk("k", int'(o.k), e.k);
            chk("n", int'(o.n), e.n);
            chk("rsel", int'(o.rsel), int'(e.n % 2 == 0));
            chk("stage_done", int'(o.sd), int'(e.last));
            if (seen_sd) chk("drain_gap", gap, pd_of(d) + gap_st);
            seen_sd = e.last; gap = 0; gap_st = 0;
          end
        end else begin
          chk("sd_no_av", int'(o.sd), 0);
          if (seen_sd) begin
            gap++;
            if (st) gap_st++;
          end
        end
      end
      @(posedge clk); #1;
    end
    stall[d] = 1'b0;
    chk("done_seen", int'(got_done), 1);
    @(negedge clk);
    chk_idle(d);
    if (hold) begin
      @(posedge clk); #1;
      @(negedge clk);
      o = obs[d];
      chk("restart_valid", int'(o.av | o.lv), 1);
      chk("restart_a0", int'(o.a0), 0);
      chk("restart_busy", int'(o.busy), 1);
      chk("restart_n", int'(o.n), 0);
      start[d] = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
    end
  endtask

  task automatic abort_mid_run(input int d);
    obs_t o; bit found; int ndone, nbusy;
    found = 0; ndone = 0; nbusy = 0;
    @(posedge clk); #1;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      o = obs[d];
      if (o.av && o.n == 2'd1) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("reach_s1", int'(found), 1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_reset(d);
    @(posedge clk); #1; rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ndone += int'(obs[d].done);
      nbusy += int'(obs[d].busy);
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", nbusy, 0);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 1, 0}; tbl[1]  = '{0, 1, 2, 3, 0};
    tbl[2]  = '{0, 2, 4, 5, 0}; tbl[3]  = '{0, 3, 6, 7, 0};
    tbl[4]  = '{1, 0, 0, 2, 0}; tbl[5]  = '{1, 1, 1, 3, 2};
    tbl[6]  = '{1, 2, 4, 6, 0}; tbl[7]  = '{1, 3, 5, 7, 2};
    tbl[8]  = '{2, 0, 0, 4, 0}; tbl[9]  = '{2, 1, 1, 5, 1};
    tbl[10] = '{2, 2, 2, 6, 2}; tbl[11] = '{2, 3, 3, 7, 3};
    start[0] = 1'b0; start[1] = 1'b0;
    stall[0] = 1'b0; stall[1] = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    @(posedge clk); #1; rst = 1'b1;

    // stall while idle must not wake the unit
    @(posedge clk); #1; stall[0] = 1'b1; stall[1] = 1'b1;
    @(negedge clk); chk_idle(0); chk_idle(1);
    @(posedge clk); #1; stall[0] = 1'b0; stall[1] = 1'b0;

    run_fft(0, 0, 0, 1);
    run_fft(1, 0, 0, 1);
    run_fft(0, 2, 0, 0);
    run_fft(1, 2, 0, 0);
    for (int i = 0; i < 6; i++) run_fft(i % 2, 1, 0, 0);
    abort_mid_run(1);
    run_fft(1, 0, 0, 0);
    abort_mid_run(0);
    run_fft(0, 0, 0, 0);
    run_fft(0, 0, 1, 0);
    run_fft(1, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
